// File: rtl/psi_match_pkg.sv
// Shared definitions for the port/PID match engine.
//   - default geometry of the search table and the bit widths derived from it
//   - FSM state encoding
//   - default null PID and the key packing helper {port, 3'b0, pid}
package psi_match_pkg;

    localparam int BANKS_DEF      = 4;
    localparam int BANK_DEPTH_DEF = 128;
    localparam int BANK_BITS      = $clog2(BANKS_DEF);
    localparam int ROW_BITS       = $clog2(BANK_DEPTH_DEF);

    localparam logic [12:0] NULL_PID_DEF = 13'h1FFF;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_HDR    = 3'd2,
        ST_SEARCH = 3'd3,
        ST_DONE   = 3'd4
    } match_state_e;

    // Table entries and search keys share this layout; bits [15:13] are
    // always zero, so an all-ones (cleared) entry can never match a key.
    function automatic logic [31:0] pack_key(input logic [15:0] port,
                                             input logic [12:0] pid);
        return {port, 3'b000, pid};
    endfunction

endpackage

// File: rtl/psi_pid_match_engine_if.sv
// Input bus of the match engine: packet payload stream plus table write port.
//   payload_in_valid/start/data : packet words, start marks the first word
//   cfg_wr/cfg_index/cfg_data   : host write of one table entry
// master drives the bus (packet source / host), slave is the engine.
interface psi_pid_match_engine_if #(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = 16
);
    logic                  payload_in_valid;
    logic                  payload_in_start;
    logic [DATA_WIDTH-1:0] payload_in_data;
    logic                  cfg_wr;
    logic [IDX_WIDTH-1:0]  cfg_index;
    logic [31:0]           cfg_data;

    modport master (
        output payload_in_valid, payload_in_start, payload_in_data,
        output cfg_wr, cfg_index, cfg_data
    );

    modport slave (
        input payload_in_valid, payload_in_start, payload_in_data,
        input cfg_wr, cfg_index, cfg_data
    );
endinterface

// File: rtl/psi_match_bank.sv
// One bank of the match table: simple dual-port RAM with a registered read
// port and an equality comparator on the read data.
//   payload_clk, avalon_rst : clock, async active-high reset (read register only)
//   wr_en, wr_row, wr_data  : write port
//   rd_row                  : read address, data appears one cycle later
//   key, hit                : search key and combinational compare result
// Read-before-write: a row read and written in the same cycle returns old data.
module psi_match_bank #(
    parameter int BANK_DEPTH = 128,
    parameter int ROW_BITS   = 7
) (
    input  logic                payload_clk,
    input  logic                avalon_rst,
    input  logic                wr_en,
    input  logic [ROW_BITS-1:0] wr_row,
    input  logic [31:0]         wr_data,
    input  logic [ROW_BITS-1:0] rd_row,
    input  logic [31:0]         key,
    output logic                hit
);

    logic [31:0] mem_r [BANK_DEPTH];
    logic [31:0] rd_data_r;

    // RAM write port
    always_ff @(posedge payload_clk) begin
        if (wr_en) begin
            mem_r[wr_row] <= wr_data;
        end
    end

    // Registered read port; resets to all-ones so it can never produce a hit
    always_ff @(posedge payload_clk or posedge avalon_rst) begin
        if (avalon_rst) begin
            rd_data_r <= 32'hFFFF_FFFF;
        end else begin
            rd_data_r <= mem_r[rd_row];
        end
    end

    assign hit = (rd_data_r == key);

endmodule

// File: rtl/psi_pid_match_engine.sv
// Port/PID match engine. Builds a {port, pid} key from the first two valid
// words of each packet and searches BANKS parallel banks, one row per cycle.
//   payload_clk, avalon_rst : clock, async active-high reset
//   bus (slave)             : packet stream and table write port
//   max_rows                : search row limit (0 or > BANK_DEPTH = full depth)
//   init_busy               : table clear in progress
//   search_over             : idle, ready for a new key
//   result_valid            : one-cycle result pulse
//   match, match_index      : hit flag and bank*BANK_DEPTH+row of the hit
//   null_pid                : key carried NULL_PID (no search done)
//   drop_cnt                : saturating count of packets dropped while busy
module psi_pid_match_engine
    import psi_match_pkg::*;
#(
    parameter int          BANKS      = BANKS_DEF,
    parameter int          BANK_DEPTH = BANK_DEPTH_DEF,
    parameter int          DATA_WIDTH = 32,
    parameter int          IDX_WIDTH  = 16,
    parameter logic [12:0] NULL_PID   = NULL_PID_DEF
) (
    input  logic                          payload_clk,
    input  logic                          avalon_rst,
    psi_pid_match_engine_if.slave         bus,
    input  logic [$clog2(BANK_DEPTH):0]   max_rows,
    output logic                          init_busy,
    output logic                          search_over,
    output logic                          result_valid,
    output logic                          match,
    output logic [IDX_WIDTH-1:0]          match_index,
    output logic                          null_pid,
    output logic [15:0]                   drop_cnt
);

    localparam int RB      = $clog2(BANK_DEPTH);
    localparam int BB      = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam int ENTRIES = BANKS * BANK_DEPTH;

    match_state_e  state_r;
    match_state_e  state_nxt_s;

    logic [RB-1:0] init_row_r;
    logic [RB:0]   rd_row_r;
    logic [RB:0]   cmp_row_r;
    logic          cmp_vld_r;
    logic [RB:0]   limit_r;
    logic [15:0]   port_r;
    logic [12:0]   pid_r;
    logic [31:0]   key_s;

    logic          cfg_pend_r;
    logic [BB-1:0] wr_bank_r;
    logic [RB-1:0] wr_row_r;
    logic [31:0]   wr_data_r;

    logic [BANKS-1:0] bank_wr_en_s;
    logic [BANKS-1:0] bank_hit_s;
    logic [RB-1:0]    bank_wr_row_s;
    logic [31:0]      bank_wr_data_s;

    logic          start_s;
    logic          word_s;
    logic [12:0]   pid_in_s;
    logic          issue_s;
    logic          hit_any_s;
    logic [BB-1:0] hit_bank_s;
    logic          hit_vld_s;
    logic          last_s;
    logic          busy_s;
    logic          unused_data_s;

    assign start_s       = bus.payload_in_valid & bus.payload_in_start;
    assign word_s        = bus.payload_in_valid & ~bus.payload_in_start;
    assign pid_in_s      = bus.payload_in_data[20:8];
    assign unused_data_s = ^bus.payload_in_data;
    assign key_s         = pack_key(port_r, pid_r);
    assign busy_s        = (state_r == ST_HDR) || (state_r == ST_SEARCH) || (state_r == ST_DONE);

    // Reads are issued only up to the sampled limit; the compare stage sees
    // the row read in the previous cycle.
    assign issue_s   = (state_r == ST_SEARCH) && (rd_row_r < limit_r);
    assign hit_vld_s = cmp_vld_r && hit_any_s;
    assign last_s    = cmp_vld_r && (cmp_row_r == (limit_r - (RB+1)'(1)));

    // Table write mux: the clear sequence owns the write port during INIT
    assign bank_wr_row_s  = (state_r == ST_INIT) ? init_row_r : wr_row_r;
    assign bank_wr_data_s = (state_r == ST_INIT) ? 32'hFFFF_FFFF : wr_data_r;

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        assign bank_wr_en_s[b] = (state_r == ST_INIT) ||
                                 (cfg_pend_r && (wr_bank_r == BB'(b)));

        psi_match_bank #(
            .BANK_DEPTH (BANK_DEPTH),
            .ROW_BITS   (RB)
        ) u_bank (
            .payload_clk (payload_clk),
            .avalon_rst  (avalon_rst),
            .wr_en       (bank_wr_en_s[b]),
            .wr_row      (bank_wr_row_s),
            .wr_data     (bank_wr_data_s),
            .rd_row      (rd_row_r[RB-1:0]),
            .key         (key_s),
            .hit         (bank_hit_s[b])
        );
    end

    // Priority encoder: scanning downwards lets the lowest hitting bank win
    always_comb begin
        hit_any_s  = 1'b0;
        hit_bank_s = '0;
        for (int b = BANKS - 1; b >= 0; b--) begin
            if (bank_hit_s[b]) begin
                hit_any_s  = 1'b1;
                hit_bank_s = BB'(b);
            end else begin
                hit_any_s  = hit_any_s;
            end
        end
    end

    // FSM state register
    always_ff @(posedge payload_clk or posedge avalon_rst) begin
        if (avalon_rst) begin
            state_r <= ST_INIT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (init_row_r == RB'(BANK_DEPTH - 1)) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
            ST_IDLE: begin
                if (start_s) begin
                    state_nxt_s = ST_HDR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (word_s && (pid_in_s == NULL_PID)) begin
                    state_nxt_s = ST_DONE;
                end else if (word_s) begin
                    state_nxt_s = ST_SEARCH;
                end else begin
                    state_nxt_s = ST_HDR;
                end
            end
            ST_SEARCH: begin
                if (hit_vld_s || last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_SEARCH;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_INIT;
        endcase
    end

    // Host table writes land one cycle after the strobe; out-of-range
    // indices and writes during the clear sequence are discarded
    always_ff @(posedge payload_clk or posedge avalon_rst) begin
        if (avalon_rst) begin
            cfg_pend_r <= 1'b0;
            wr_bank_r  <= '0;
            wr_row_r   <= '0;
            wr_data_r  <= 32'h0000_0000;
        end else begin
            cfg_pend_r <= bus.cfg_wr && (state_r != ST_INIT) &&
                          (32'(bus.cfg_index) < 32'(ENTRIES));
            wr_bank_r  <= BB'(bus.cfg_index >> RB);
            wr_row_r   <= bus.cfg_index[RB-1:0];
            wr_data_r  <= bus.cfg_data;
        end
    end

    // Search pipeline: row read counter, compare-stage row tag and limit
    always_ff @(posedge payload_clk or posedge avalon_rst) begin
        if (avalon_rst) begin
            init_row_r <= '0;
            rd_row_r   <= '0;
            cmp_row_r  <= '0;
            cmp_vld_r  <= 1'b0;
            limit_r    <= (RB+1)'(BANK_DEPTH);
        end else begin
            cmp_row_r <= rd_row_r;
            cmp_vld_r <= issue_s;
            if (state_r == ST_INIT) begin
                init_row_r <= init_row_r + RB'(1);
            end else begin
                init_row_r <= init_row_r;
            end
            if (state_r == ST_HDR) begin
                rd_row_r <= '0;
            end else if (issue_s) begin
                rd_row_r <= rd_row_r + (RB+1)'(1);
            end else begin
                rd_row_r <= rd_row_r;
            end
            // Limit is frozen when the search starts
            if ((state_r == ST_HDR) && (state_nxt_s == ST_SEARCH)) begin
                if ((max_rows == '0) || (max_rows > (RB+1)'(BANK_DEPTH))) begin
                    limit_r <= (RB+1)'(BANK_DEPTH);
                end else begin
                    limit_r <= max_rows;
                end
            end else begin
                limit_r <= limit_r;
            end
        end
    end

    // Key capture and registered result outputs
    always_ff @(posedge payload_clk or posedge avalon_rst) begin
        if (avalon_rst) begin
            port_r       <= 16'h0000;
            pid_r        <= 13'h0000;
            init_busy    <= 1'b1;
            search_over  <= 1'b0;
            result_valid <= 1'b0;
            match        <= 1'b0;
            match_index  <= '0;
            null_pid     <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state_r)
                ST_INIT: begin
                    if (state_nxt_s == ST_IDLE) begin
                        init_busy   <= 1'b0;
                        search_over <= 1'b1;
                    end else begin
                        init_busy   <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (start_s) begin
                        port_r      <= bus.payload_in_data[15:0];
                        match       <= 1'b0;
                        match_index <= '0;
                        null_pid    <= 1'b0;
                        search_over <= 1'b0;
                    end else begin
                        search_over <= 1'b1;
                    end
                end
                ST_HDR: begin
                    if (word_s) begin
                        pid_r <= pid_in_s;
                        if (pid_in_s == NULL_PID) begin
                            null_pid     <= 1'b1;
                            match        <= 1'b0;
                            result_valid <= 1'b1;
                        end else begin
                            null_pid     <= 1'b0;
                        end
                    end else begin
                        pid_r <= pid_r;
                    end
                end
                ST_SEARCH: begin
                    if (hit_vld_s) begin
                        result_valid <= 1'b1;
                        match        <= 1'b1;
                        match_index  <= IDX_WIDTH'(hit_bank_s) * IDX_WIDTH'(BANK_DEPTH)
                                        + IDX_WIDTH'(cmp_row_r);
                    end else if (last_s) begin
                        result_valid <= 1'b1;
                        match        <= 1'b0;
                        match_index  <= '0;
                    end else begin
                        result_valid <= 1'b0;
                    end
                end
                ST_DONE: search_over <= 1'b1;
                default: search_over <= 1'b0;
            endcase
        end
    end

    // Saturating count of packet starts that arrive while a key is in flight
    always_ff @(posedge payload_clk or posedge avalon_rst) begin
        if (avalon_rst) begin
            drop_cnt <= 16'h0000;
        end else if (start_s && busy_s && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'h0001;
        end else begin
            drop_cnt <= drop_cnt;
        end
    end

endmodule

// File: tb/tb_psi_pid_match_engine.sv
// Directed self-checking bench for psi_pid_match_engine (default geometry:
// 4 banks x 128 rows). Latencies are counted in clock edges from the edge
// that samples the second packet word.
module tb_psi_pid_match_engine;

    localparam int DEPTH   = 1 << psi_match_pkg::ROW_BITS;
    localparam int OOR_IDX = 1 << (psi_match_pkg::BANK_BITS + psi_match_pkg::ROW_BITS);

    logic        payload_clk = 1'b0;
    logic        avalon_rst;
    logic [7:0]  max_rows;
    logic        init_busy;
    logic        search_over;
    logic        result_valid;
    logic        match;
    logic [15:0] match_index;
    logic        null_pid;
    logic [15:0] drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int lat;

    psi_pid_match_engine_if #(.DATA_WIDTH(32), .IDX_WIDTH(16)) bus ();

    psi_pid_match_engine dut (
        .payload_clk  (payload_clk),
        .avalon_rst   (avalon_rst),
        .bus          (bus),
        .max_rows     (max_rows),
        .init_busy    (init_busy),
        .search_over  (search_over),
        .result_valid (result_valid),
        .match        (match),
        .match_index  (match_index),
        .null_pid     (null_pid),
        .drop_cnt     (drop_cnt)
    );

    always #5 payload_clk = ~payload_clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge payload_clk);
        #1;
    endtask

    task automatic cfg_write(input logic [15:0] idx, input logic [31:0] val);
        bus.cfg_wr    = 1'b1;
        bus.cfg_index = idx;
        bus.cfg_data  = val;
        tick();
        bus.cfg_wr    = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20; i++) begin
            if (search_over) break;
            tick();
        end
        check_eq("idle", 32'(search_over), 32'd1);
    endtask

    // Counts sampled cycles with init_busy high, starting right after release
    task automatic count_init();
        int cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge payload_clk);
            if (init_busy) cnt++;
            else break;
        end
        check_eq("init_len", 32'(cnt), 32'(DEPTH));
        check_eq("init_search_over", 32'(search_over), 32'd1);
        tick();
    endtask

    // Sends a two-word packet. drop_at injects a spurious start at that
    // latency count; rst_at asserts reset instead of waiting for the result.
    task automatic send_pkt(input logic [15:0] port, input logic [12:0] pid,
                            input int drop_at, input int rst_at, output int l);
        bit done = 1'b0;
        bus.payload_in_start = 1'b1;
        bus.payload_in_valid = 1'b1;
        bus.payload_in_data  = 32'(port);
        tick();
        bus.payload_in_start = 1'b0;
        bus.payload_in_data  = 32'({pid, 8'h00});
        l = 0;
        while (!done && l < 300) begin
            tick();
            l++;
            bus.payload_in_valid = 1'b0;
            bus.payload_in_start = 1'b0;
            bus.payload_in_data  = 32'h0;
            if (result_valid) begin
                done = 1'b1;
            end else if (l == rst_at) begin
                avalon_rst = 1'b1;
                #1;
                done = 1'b1;
                l = -2;
            end else if (l == drop_at) begin
                bus.payload_in_start = 1'b1;
                bus.payload_in_valid = 1'b1;
                bus.payload_in_data  = 32'h0000_ABCD;
            end
        end
        if (!done) l = -1;
    endtask

    task automatic expect_result(input string tag, input int l, input int exp_lat,
                                 input logic exp_match, input logic [15:0] exp_idx,
                                 input logic exp_null);
        check_eq({tag, "_lat"}, 32'(l), 32'(exp_lat));
        check_eq({tag, "_match"}, 32'(match), 32'(exp_match));
        check_eq({tag, "_index"}, 32'(match_index), 32'(exp_idx));
        check_eq({tag, "_null"}, 32'(null_pid), 32'(exp_null));
        tick();
        check_eq({tag, "_pulse"}, 32'(result_valid), 32'd0);
        check_eq({tag, "_over"}, 32'(search_over), 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_init_busy"}, 32'(init_busy), 32'd1);
        check_eq({tag, "_search_over"}, 32'(search_over), 32'd0);
        check_eq({tag, "_result_valid"}, 32'(result_valid), 32'd0);
        check_eq({tag, "_match"}, 32'(match), 32'd0);
        check_eq({tag, "_index"}, 32'(match_index), 32'd0);
        check_eq({tag, "_null"}, 32'(null_pid), 32'd0);
        check_eq({tag, "_drop"}, 32'(drop_cnt), 32'd0);
    endtask

    initial begin
        avalon_rst           = 1'b1;
        max_rows             = 8'd0;
        bus.payload_in_valid = 1'b0;
        bus.payload_in_start = 1'b0;
        bus.payload_in_data  = 32'h0;
        bus.cfg_wr           = 1'b0;
        bus.cfg_index        = 16'h0;
        bus.cfg_data         = 32'h0;
        repeat (3) tick();
        check_reset_vals("rst");

        // Clear sequence length, then a key that only an all-ones entry resembles
        avalon_rst = 1'b0;
        count_init();
        wait_idle();
        send_pkt(16'hFFFF, 13'h1FFE, -1, -1, lat);
        expect_result("init_miss", lat, 130, 1'b0, 16'd0, 1'b0);

        // Hit in bank 2 row 5
        cfg_write(16'd261, 32'h0012_0100);
        wait_idle();
        send_pkt(16'h0012, 13'h0100, -1, -1, lat);
        expect_result("hit261", lat, 8, 1'b1, 16'd261, 1'b0);

        // Same key in bank 0 and bank 1 at row 3: lowest bank wins
        cfg_write(16'd3, 32'h0034_0055);
        cfg_write(16'd131, 32'h0034_0055);
        wait_idle();
        send_pkt(16'h0034, 13'h0055, -1, -1, lat);
        expect_result("prio", lat, 6, 1'b1, 16'd3, 1'b0);

        // Row-limit boundaries around an entry at row 10
        cfg_write(16'd10, 32'h0056_0077);
        max_rows = 8'd8;
        wait_idle();
        send_pkt(16'h0056, 13'h0077, -1, -1, lat);
        expect_result("lim8", lat, 10, 1'b0, 16'd0, 1'b0);
        max_rows = 8'd10;
        send_pkt(16'h0056, 13'h0077, -1, -1, lat);
        expect_result("lim10", lat, 12, 1'b0, 16'd0, 1'b0);
        max_rows = 8'd11;
        send_pkt(16'h0056, 13'h0077, -1, -1, lat);
        expect_result("lim11", lat, 13, 1'b1, 16'd10, 1'b0);
        max_rows = 8'd200;
        send_pkt(16'h0056, 13'h0077, -1, -1, lat);
        expect_result("lim200", lat, 13, 1'b1, 16'd10, 1'b0);
        max_rows = 8'd0;

        // Out-of-range index must not alias onto bank 0 row 0
        cfg_write(16'(OOR_IDX), 32'h0078_0099);
        wait_idle();
        send_pkt(16'h0078, 13'h0099, -1, -1, lat);
        expect_result("oor", lat, 130, 1'b0, 16'd0, 1'b0);

        // Null PID bypasses the search
        send_pkt(16'h0012, 13'h1FFF, -1, -1, lat);
        expect_result("null", lat, 1, 1'b0, 16'd0, 1'b1);

        // A start during the search is dropped and the search completes
        check_eq("drop0", 32'(drop_cnt), 32'd0);
        send_pkt(16'h0012, 13'h0100, 2, -1, lat);
        expect_result("busy_hit", lat, 8, 1'b1, 16'd261, 1'b0);
        check_eq("drop1", 32'(drop_cnt), 32'd1);

        // Hold start high in HDR until the drop counter saturates
        wait_idle();
        bus.payload_in_start = 1'b1;
        bus.payload_in_valid = 1'b1;
        bus.payload_in_data  = 32'h0000_0001;
        tick();
        for (int i = 0; i < 70000; i++) tick();
        bus.payload_in_start = 1'b0;
        bus.payload_in_valid = 1'b0;
        tick();
        check_eq("drop_sat", 32'(drop_cnt), 32'h0000_FFFF);
        bus.payload_in_valid = 1'b1;
        bus.payload_in_data  = 32'({13'h1FFF, 8'h00});
        tick();
        bus.payload_in_valid = 1'b0;
        check_eq("sat_null_pulse", 32'(result_valid), 32'd1);
        wait_idle();

        // Reset during a search wipes outputs and the table
        send_pkt(16'h0012, 13'h0100, -1, 3, lat);
        check_eq("rst_mid_taken", 32'(lat), 32'hFFFF_FFFE);
        check_reset_vals("rst_mid");
        @(posedge payload_clk);
        #1;
        avalon_rst = 1'b0;
        count_init();
        wait_idle();
        send_pkt(16'h0012, 13'h0100, -1, -1, lat);
        expect_result("after_rst", lat, 130, 1'b0, 16'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/psi_pid_match_engine.md
Name: psi_pid_match_engine

Overview:
- Parametrised successor of the single-key port/PID table matcher.
- Extracts a {port[15:0], pid[12:0]} key from the first two valid words of each received packet and searches a host-written table of BANKS x BANK_DEPTH 32-bit entries, checking all banks in parallel, one row per cycle.
- Reports hit/miss, the matched list index, null-PID bypass and a dropped-packet count.
- Sits in the ts_process path ahead of the PSI filter / remux logic.

Parameters:
- BANKS, 4, number of parallel RAM banks (power of 2, 1..16).
- BANK_DEPTH, 128, rows per bank (power of 2, 2..1024).
- DATA_WIDTH, 32, payload word width (>=21).
- IDX_WIDTH, 16, width of match_index (>= log2(BANKS*BANK_DEPTH)).
- NULL_PID, 13'h1FFF, PID that bypasses search.

Ports:
- payload_clk  in  1  clock for all logic.
- avalon_rst  in  1  asynchronous, active-high reset.
- payload_in_valid  in  1  word valid.
- payload_in_start  in  1  first word of packet.
- payload_in_data  in  DATA_WIDTH  packet word.
- cfg_wr  in  1  table write strobe.
- cfg_index  in  IDX_WIDTH  entry index; bank = index/BANK_DEPTH, row = index%BANK_DEPTH.
- cfg_data  in  32  entry value {port, 3'b0, pid}.
- max_rows  in  log2(BANK_DEPTH)+1  runtime search limit; 0 or >BANK_DEPTH means BANK_DEPTH.
- init_busy  out  1  table clear in progress.
- search_over  out  1  engine idle, ready for a new key.
- result_valid  out  1  one-cycle result pulse.
- match  out  1  hit flag, qualified by result_valid.
- match_index  out  IDX_WIDTH  bank*BANK_DEPTH+row of the hit; 0 on miss.
- null_pid  out  1  key carried NULL_PID, qualified by result_valid.
- drop_cnt  out  16  packets ignored while busy, saturating.

Behaviour:
- Reset values: init_busy=1, search_over=0, result_valid=0, match=0, match_index=0, null_pid=0, drop_cnt=0, FSM in INIT, row counter 0.
- INIT:
  - Writes all-ones to row r of every bank, r=0..BANK_DEPTH-1, one row per cycle.
  - Lasts exactly BANK_DEPTH cycles, then goes to IDLE with init_busy=0 and search_over=1.
  - During INIT, cfg_wr is ignored and packets are ignored without counting.
  - An all-ones entry can never match, because key bits [15:13] are always 0.
- Table write: cfg_wr in IDLE/HDR/SEARCH/DONE writes cfg_data to the addressed row one cycle later. An index >= BANKS*BANK_DEPTH is ignored. The read port is read-before-write: a row written in the same cycle it is read returns old data.
- IDLE: on start&valid, latch key[31:16]=data[15:0], clear match/null_pid, search_over=0, go to HDR.
- HDR: wait for the next valid word (call that cycle T). Latch key[15:0]={3'b0, data[20:8]}.
  - If the PID equals NULL_PID, go to DONE with null_pid=1, match=0; result_valid fires at T+1.
  - Otherwise issue a read of row 0 at T+1 and go to SEARCH.
- SEARCH:
  - Synchronous RAM read plus one register stage: row r data is compared at T+2+r across all banks.
  - On multiple bank hits, the lowest bank wins.
  - Hit at row r: result_valid=1, match=1, match_index=bank*BANK_DEPTH+r at T+3+r.
  - If no hit after row L-1 (L = effective max_rows): result_valid=1, match=0, match_index=0 at T+2+L.
  - Reads already issued beyond the hit row are discarded.
- DONE: result_valid is high for exactly one cycle. Next cycle: IDLE, search_over=1. match, match_index and null_pid hold until the next packet start.
- Busy drop: start&valid while in HDR/SEARCH/DONE drops that packet, drop_cnt+1 (saturates at 16'hFFFF); the current search continues. A start while in IDLE is accepted normally.
- A start arriving in HDR re-latches nothing and is counted as a drop.
- max_rows is sampled at the HDR->SEARCH transition; changes mid-search have no effect.
- Reset mid-operation: immediately returns to reset values and re-runs INIT (table contents are lost).

Decomposition:
- Package psi_match_pkg:
  - localparams BANK_BITS=clog2(BANKS), ROW_BITS=clog2(BANK_DEPTH).
  - FSM state encoding INIT/IDLE/HDR/SEARCH/DONE.
  - NULL_PID default.
  - key packing function {port, 3'b0, pid}.
- Sub-module psi_match_bank: one simple dual-port RAM (BANK_DEPTH x 32, write port + registered read port) plus its comparator. Instantiated BANKS times in a generate loop; the top holds the FSM and priority encoder.

Test Plan:
- Init: release reset -> init_busy=1 for exactly BANK_DEPTH(128) cycles. Then a packet with port 0xFFFF and PID 0x1FFE -> match=0 at T+2+128.
- Hit: write index 261 (bank 2, row 5) = 0x00120100; send port 0x0012, word2 data[20:8]=0x0100 -> result_valid at T+8, match=1, match_index=261.
- Priority/limit:
  - Same key at indices 3 and 131 -> match_index=3.
  - Same key only at row 10, max_rows=8 -> miss at T+10.
- Null: PID 0x1FFF -> result_valid at T+1, null_pid=1, match=0, no RAM search.
- Busy drop: second start during SEARCH -> first result unaffected, drop_cnt=1; 70000 drops -> drop_cnt=0xFFFF.
- Reset mid-search: assert avalon_rst during SEARCH -> all outputs at reset values, INIT reruns, previously written entries no longer match.
